seg_display_scanner: RTL and testbench
======================================

# seg_display_scanner

Time-multiplexed driver for a bank of common-anode seven-segment digits. It latches a packed hexadecimal value from the CPU side and scans one digit per refresh slot. For each slot it presents that digit's 4-bit nibble to the downstream binary-to-segment decoder and drives the matching active-low anode. It sits between the CPU's memory-mapped display register and the segment decoder. The decoder stays purely combinational; this block owns all timing, buffering and blanking.

## Interface
- DIGITS, 8: number of digits scanned; index width is clog2(DIGITS), minimum 1.
- REFRESH_DIV, 100000: clock cycles each digit stays lit; must be ≥ 2.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture strobe for value; sampled every cycle.
- value  input  4*DIGITS  packed nibbles; digit i is value[4i+3:4i]; digit 0 is rightmost.
- blank_lz  input  1  when 1, leading-zero digits are blanked; sampled every cycle.
- binary  output  4  nibble of the currently lit digit, to the decoder's binary input.
- anode  output  DIGITS  active-low digit enables; at most one bit low.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps to 0. tick = (cnt == REFRESH_DIV-1).
- Digit index idx advances on tick and wraps from DIGITS-1 to 0. Wrap cycle: wrap = tick && idx == DIGITS-1.
- Double buffer:
  - load=1 writes value into pend and sets pend_v.
  - On wrap with pend_v=1 and load=0: disp <= pend and pend_v clears.
  - On wrap with load=1: disp <= value directly and pend_v clears. The same-cycle value wins.
  - load=1 with no wrap: pend is overwritten (last load wins) and pend_v stays set.
  - disp therefore changes only at frame boundaries, so no partial-frame tearing.
- Blanking: digit i (i ≥ 1) is blanked when blank_lz=1 and disp nibbles DIGITS-1 down to i are all zero. Digit 0 is never blanked.
- Output registers, updated every cycle from next-state idx and disp:
  - binary <= disp nibble at idx_next.
  - anode <= all ones if that digit is blanked, else ~(1 << idx_next).
  - frame_done <= wrap.
- Reset values:
  - cnt, idx, disp, pend = 0 and pend_v = 0.
  - binary = 4'h0, anode = all ones, frame_done = 0.
  - reset has priority over load and tick.

## Timing
- All outputs are registered; no combinational input-to-output path.
- First cycle after reset deasserts: anode = ~1 (digit 0 lit), binary = 0.
- The digit change appears on the outputs in the same edge that advances idx. Each digit is lit for exactly REFRESH_DIV cycles; one frame = DIGITS*REFRESH_DIV cycles.
- Load-to-display latency:
  - A load in the wrap cycle shows on the digit-0 outputs at that same edge.
  - Otherwise the value appears at the next wrap edge, at most DIGITS*REFRESH_DIV cycles later.
- frame_done is high for the one cycle after the wrap edge, coincident with digit 0 being lit.
- blank_lz changes take effect on the next edge for the digit being presented.
- Reset mid-frame:
  - The next cycle returns all outputs to their reset values.
  - Pending and displayed data are discarded.

## Test plan
Run with DIGITS=4, REFRESH_DIV=4.
- Reset, then no load -> anode is 1111 during reset; then 1110, 1101, 1011, 0111, each for 4 cycles; binary=0 throughout; frame_done pulses once every 16 cycles.
- load=1 with value=16'h1A3F at cycle 5 after reset -> binary stays 0 until the wrap edge (cycle 16). Then binary sequence is F, 3, A, 1 with anodes 1110, 1101, 1011, 0111.
- Two loads, 16'h1111 then 16'h2222, inside one frame -> the next frame shows 2 on all digits; 1 is never displayed.
- load=1 with value=16'h00C0 in exactly the wrap cycle, blank_lz=1 -> the same edge shows digit 0 (binary 0, anode 1110); digit 1 shows C with anode 1101; digits 2 and 3 show anode 1111. With blank_lz=0, all four anodes scan and binary is 0, C, 0, 0.
- value=16'h0000 with blank_lz=1 -> only digit 0 lights (anode 1110 in its slot); all other slots give anode 1111.
- Assert reset during digit 2 with a pending load outstanding -> the next cycle shows anode 1111, binary 0, frame_done 0. After release, scanning restarts at digit 0 showing 0; the pending value never appears.

Source files
------------

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: time-multiplexed driver for common-anode seven-segment digits.
// Latches a packed hex value, scans one digit per refresh slot and drives the
// nibble and active-low anode of the lit digit. Display data only changes at
// frame boundaries so a frame never mixes old and new digits.
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_i       synchronous active-high reset
//   load_i        capture strobe for value_i
//   value_i       packed nibbles, digit i at [4i+3:4i], digit 0 rightmost
//   blank_lz_i    blank leading-zero digits when high
//   binary_o      nibble of the lit digit, to the segment decoder
//   anode_o       active-low digit enables, at most one low
//   frame_done_o  one-cycle pulse after the last digit's slot ends
module seg_display_scanner #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  blank_lz_i,
  output logic [3:0]            binary_o,
  output logic [DIGITS-1:0]     anode_o,
  output logic                  frame_done_o
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic                  tick, wrap;

  logic [3:0]            binary_d;
  logic [DIGITS-1:0]     anode_d;
  logic                  zero_above;

  // Prescaler, digit index and double buffer.
  always_comb begin
    tick     = (cnt_q == CntMax);
    wrap     = tick && (idx_q == IdxMax);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
    pend_d   = load_i ? value_i : pend_q;
    pend_v_d = pend_v_q | load_i;
    disp_d   = disp_q;
    if (wrap) begin
      // A load in the wrap cycle bypasses the pending buffer.
      if (load_i) begin
        disp_d = value_i;
      end else if (pend_v_q) begin
        disp_d = pend_q;
      end
      pend_v_d = 1'b0;
    end
  end

  // Outputs are computed from next-state so the digit change lands on the same
  // edge that advances idx. zero_above tracks whether every nibble from the
  // top down to the current one is zero.
  always_comb begin
    binary_d   = 4'h0;
    anode_d    = '1;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_d[4*i +: 4] == 4'h0);
      if (idx_d == IdxW'(i)) begin
        binary_d = disp_d[4*i +: 4];
        if (!(blank_lz_i && (i != 0) && zero_above)) begin
          anode_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      binary_o     <= 4'h0;
      anode_o      <= '1;
      frame_done_o <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      binary_o     <= binary_d;
      anode_o      <= anode_d;
      frame_done_o <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner with DIGITS=4, REFRESH_DIV=4.
// The reference model tracks only the number of edges since reset and derives
// slot position arithmetically; the displayed value is swapped at frame ends.
module tb_seg_display_scanner;

  localparam int unsigned D = 4;
  localparam int unsigned R = 4;
  localparam int unsigned F = D * R;

  logic        clk;
  logic        rst;
  logic        ld;
  logic [15:0] val;
  logic        blz;
  logic [3:0]  binary;
  logic [3:0]  anode;
  logic        frame_done;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model state.
  int unsigned k;          // non-reset edges since reset
  logic [15:0] shown;
  logic [15:0] pend;
  logic        pend_ok;
  logic [3:0]  exp_bin;
  logic [3:0]  exp_an;
  logic        exp_fd;

  seg_display_scanner #(
    .DIGITS      (D),
    .REFRESH_DIV (R)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .load_i       (ld),
    .value_i      (val),
    .blank_lz_i   (blz),
    .binary_o     (binary),
    .anode_o      (anode),
    .frame_done_o (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  // Apply the edge with the current inputs to the model.
  task automatic model_edge();
    int unsigned d;
    logic        w;
    if (rst) begin
      k       = 0;
      shown   = '0;
      pend    = '0;
      pend_ok = 1'b0;
      exp_bin = 4'h0;
      exp_an  = 4'hF;
      exp_fd  = 1'b0;
    end else begin
      w = ((k % F) == F - 1);
      if (ld) begin
        pend    = val;
        pend_ok = 1'b1;
      end
      if (w && pend_ok) begin
        shown   = pend;
        pend_ok = 1'b0;
      end
      k++;
      d       = (k / R) % D;
      exp_bin = 4'((shown >> (4 * d)) & 16'hF);
      if (blz && d != 0 && (shown >> (4 * d)) == 16'h0) exp_an = 4'hF;
      else exp_an = ~(4'b0001 << d);
      exp_fd = w;
    end
  endtask

  // One clock: inputs already set, update model at the edge, compare mid-cycle.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("binary", {28'h0, binary}, {28'h0, exp_bin});
    check_eq("anode", {28'h0, anode}, {28'h0, exp_an});
    check_eq("frame_done", {31'h0, frame_done}, {31'h0, exp_fd});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    k = 0; shown = '0; pend = '0; pend_ok = 1'b0;
    exp_bin = 4'h0; exp_an = 4'hF; exp_fd = 1'b0;
    rst = 1'b1; ld = 1'b0; val = '0; blz = 1'b0;
    run(3);
    rst = 1'b0;

    // Idle scan, then load 1A3F five cycles in.
    run(5);
    ld = 1'b1; val = 16'h1A3F; step(); ld = 1'b0;
    run(2 * F);

    // Two loads in one frame, the second must win.
    while ((k % F) != 2) step();
    ld = 1'b1; val = 16'h1111; step(); ld = 1'b0;
    run(3);
    ld = 1'b1; val = 16'h2222; step(); ld = 1'b0;
    run(2 * F);

    // Load exactly in the wrap cycle with blanking on, then off.
    blz = 1'b1;
    while ((k % F) != F - 1) step();
    ld = 1'b1; val = 16'h00C0; step(); ld = 1'b0;
    run(F);
    blz = 1'b0;
    run(F);

    // All-zero value with blanking: only digit 0 lights.
    blz = 1'b1;
    ld = 1'b1; val = 16'h0000; step(); ld = 1'b0;
    run(2 * F);

    // Reset during digit 2 with a load pending.
    blz = 1'b0;
    ld = 1'b1; val = 16'h5678; step(); ld = 1'b0;
    run(F);
    while (((k / R) % D) != 2) step();
    ld = 1'b1; val = 16'hBEEF; step(); ld = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    run(2 * F);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      ld  = ($urandom_range(0, 9) == 0);
      val = 16'($urandom);
      if ($urandom_range(0, 3) == 0) val = val & 16'h00FF;
      if ($urandom_range(0, 49) == 0) blz = ~blz;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; ld = 1'b0;
    run(F);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
